stall_mem_responder: RTL and testbench

- Multi-cycle data-memory responder. It sits on the far side of the processor's memory-stage request interface.
- Accepts one read or write request at a time. Asserts stall while the access is in flight, then returns a one-cycle done pulse with read data.
- Replaces the single-cycle data memory, so the pipeline can be exercised against realistic memory latency.

---
 rtl/stall_mem_responder.sv | 170 +++++++++++++++++
 tb/tb_stall_mem_responder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/stall_mem_responder.sv
// stall_mem_responder
//
// Multi-cycle data-memory responder for the processor's memory-stage
// request interface. It accepts one read or write at a time, holds stall
// high while the access is in flight, and then returns a one-cycle done
// pulse. Read data and the misalignment error are returned with done.
// The memory is a register array that is cleared by reset.
//
// Parameters:
//   DEPTH_LOG2 - log2 of the number of 16-bit words (word index = addr[DEPTH_LOG2:1])
//   LATENCY    - cycles from the acceptance edge to the done cycle (1..15)
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   asynchronous reset, active-low
//   req    in   request valid
//   wr     in   1 = write, 0 = read (sampled with req)
//   addr   in   16-bit byte address
//   wdata  in   16-bit write data (sampled with req)
//   stall  out  responder busy; the requester must hold its request
//   done   out  one-cycle completion pulse
//   rdata  out  read data, valid with done for reads
//   err    out  misaligned-address error, pulsed with done
//
// Optional build macro MEM_RANDOM_STALL_EN: when defined, a 4-bit LFSR
// (x^4+x^3+1, seed 4'b1001) adds 0..3 extra wait cycles per request.

module stall_mem_responder #(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [15:0] rdata,
    output logic        err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = 5;

    logic [1:0]            state;
    logic [CNT_W-1:0]      cnt;
    logic                  lat_wr;
    logic [DEPTH_LOG2-1:0] lat_idx;
    logic                  lat_mis;
    logic [15:0]           lat_wdata;
    logic [15:0]           mem [DEPTH];

    logic                  accept;
    logic                  enter_resp;
    logic [CNT_W-1:0]      extra;
    logic [CNT_W-1:0]      load_val;
    logic                  acc_wr;
    logic [DEPTH_LOG2-1:0] acc_idx;
    logic                  acc_mis;
    logic [15:0]           acc_wdata;

    // Address bits above the word index only alias; they carry no meaning.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[15:DEPTH_LOG2+1];

    assign accept = req && ((state == IDLE) || (state == RESP));

`ifdef MEM_RANDOM_STALL_EN
    logic [3:0] lfsr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr <= 4'b1001;
        end else if (accept) begin
            lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
        end
    end

    // The pre-advance value decides this request's extra wait cycles.
    assign extra = {{(CNT_W-2){1'b0}}, lfsr[1:0]};
`else
    assign extra = '0;
`endif

    assign load_val = CNT_W'(LATENCY - 1) + extra;

    // A zero-wait request enters RESP on its own acceptance edge, before
    // the latched copy exists, so the access then uses the live inputs.
    assign enter_resp = ((state == WAIT) && (cnt == CNT_W'(1))) ||
                        (accept && (load_val == '0));

    always_comb begin
        acc_wr    = wr;
        acc_idx   = addr[DEPTH_LOG2:1];
        acc_mis   = addr[0];
        acc_wdata = wdata;
        if (state == WAIT) begin
            acc_wr    = lat_wr;
            acc_idx   = lat_idx;
            acc_mis   = lat_mis;
            acc_wdata = lat_wdata;
        end
    end

    // Request capture: only meaningful after acceptance, so no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            lat_wr    <= wr;
            lat_idx   <= addr[DEPTH_LOG2:1];
            lat_mis   <= addr[0];
            lat_wdata <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 16'h0000;
            end
        end else if (enter_resp && acc_wr && !acc_mis) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            stall <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            rdata <= 16'h0000;
        end else begin
            if (accept) begin
                cnt <= load_val;
            end

            if (enter_resp) begin
                state <= RESP;
                stall <= 1'b0;
                done  <= 1'b1;
                err   <= acc_mis;
                if (acc_mis) begin
                    rdata <= 16'h0000;
                end else if (!acc_wr) begin
                    rdata <= mem[acc_idx];
                end
            end else if (accept) begin
                state <= WAIT;
                stall <= 1'b1;
                done  <= 1'b0;
                err   <= 1'b0;
            end else if (state == WAIT) begin
                cnt   <= cnt - CNT_W'(1);
                stall <= 1'b1;
            end else if (state == RESP) begin
                state <= IDLE;
                done  <= 1'b0;
                err   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stall_mem_responder.sv
// Testbench for stall_mem_responder: directed steps followed by random
// requests, checked against a word-array reference model with a latency
// predictor (including the LFSR extra-wait rule when MEM_RANDOM_STALL_EN
// is defined).

module tb_stall_mem_responder;

    localparam int LAT = 4;

    logic        clk;
    logic        rst;
    logic        req;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        stall;
    logic        done;
    logic [15:0] rdata;
    logic        err;

    int total = 0;
    int bad   = 0;

    logic [15:0] mem_m [256];
    logic [15:0] last_rd;
    int          lfsr_m;

    int          e_lat;
    logic        e_err;
    logic [15:0] e_rd;

    stall_mem_responder #(
        .DEPTH_LOG2(8),
        .LATENCY   (LAT)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .wr   (wr),
        .addr (addr),
        .wdata(wdata),
        .stall(stall),
        .done (done),
        .rdata(rdata),
        .err  (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) mem_m[i] = 16'h0000;
        last_rd = 16'h0000;
        lfsr_m  = 9;  // seed 4'b1001
    endtask

    // Extra wait cycles come from the two low LFSR bits before it steps;
    // the step multiplies by x modulo x^4+x^3+1 in the reversed-bit sense,
    // i.e. the new low bit is the XOR of the two top bits.
    function automatic int extra_wait();
        int ex;
        int fb;
        ex = 0;
`ifdef MEM_RANDOM_STALL_EN
        ex = lfsr_m % 4;
        fb = ((lfsr_m / 8) + (lfsr_m / 4)) % 2;
        lfsr_m = ((lfsr_m * 2) % 16) + fb;
`else
        fb = 0;
`endif
        return ex + fb * 0;
    endfunction

    // Present a request at a falling edge and predict its response.
    task automatic start(input logic w, input logic [15:0] a, input logic [15:0] d);
        int idx;
        req   = 1'b1;
        wr    = w;
        addr  = a;
        wdata = d;
        idx   = (a / 2) % 256;
        e_lat = LAT + extra_wait();
        if (a % 2 == 1) begin
            e_err = 1'b1;
            e_rd  = 16'h0000;
        end else if (w) begin
            e_err = 1'b0;
            mem_m[idx] = d;
            e_rd  = last_rd;
        end else begin
            e_err = 1'b0;
            e_rd  = mem_m[idx];
        end
        last_rd = e_rd;
    endtask

    // Wait for done (bounded), checking stall, latency and the response.
    task automatic finish(input string tag, input bit drop);
        int cyc;
        bit seen;
        bit stall_bad;
        cyc = 0;
        seen = 1'b0;
        stall_bad = 1'b0;
        while (!seen && cyc < 64) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (done === 1'b1) seen = 1'b1;
            else if (stall !== 1'b1) stall_bad = 1'b1;
        end
        check({tag, "_seen"},   32'(seen), 32'd1);
        check({tag, "_lat"},    32'(cyc), 32'(e_lat));
        check({tag, "_stall"},  32'(stall_bad), 32'd0);
        check({tag, "_rstall"}, 32'(stall), 32'd0);
        check({tag, "_err"},    32'(err), 32'(e_err));
        check({tag, "_rdata"},  32'(rdata), 32'(e_rd));
        if (drop) req = 1'b0;
    endtask

    initial begin
        logic        w;
        logic [15:0] a;
        logic [15:0] d;

        rst   = 1'b1;
        req   = 1'b0;
        wr    = 1'b0;
        addr  = 16'h0000;
        wdata = 16'h0000;
        model_reset();

        // Reset held for three cycles
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_done",  32'(done),  32'd0);
        check("rst_err",   32'(err),   32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);

        start(1'b0, 16'h0010, 16'h0000);
        finish("rd_after_rst", 1'b1);

        // Write then read
        @(negedge clk);
        start(1'b1, 16'h0024, 16'hBEEF);
        finish("wr_beef", 1'b1);
        @(negedge clk);
        start(1'b0, 16'h0024, 16'h0000);
        finish("rd_beef", 1'b1);

        // Back-to-back reads with no idle bubble
        @(negedge clk);
        start(1'b0, 16'h0002, 16'h0000);
        finish("b2b_0", 1'b0);
        start(1'b0, 16'h0004, 16'h0000);
        finish("b2b_1", 1'b1);
        @(negedge clk);
        check("b2b_idle_done", 32'(done), 32'd0);

        // Misaligned write leaves memory untouched
        start(1'b1, 16'h0030, 16'h5555);
        finish("wr_5555", 1'b1);
        @(negedge clk);
        start(1'b1, 16'h0031, 16'h1234);
        finish("wr_mis", 1'b1);
        @(negedge clk);
        start(1'b0, 16'h0030, 16'h0000);
        finish("rd_after_mis", 1'b1);

        // Aliasing above the index bits
        @(negedge clk);
        start(1'b1, 16'h0202, 16'hA5A5);
        finish("wr_alias", 1'b1);
        @(negedge clk);
        start(1'b0, 16'h0002, 16'h0000);
        finish("rd_alias", 1'b1);

        // Reset in the second wait cycle drops the write
        @(negedge clk);
        start(1'b1, 16'h0008, 16'h7777);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        check("mid_stall_before", 32'(stall), 32'd1);
        rst = 1'b0;
        req = 1'b0;
        #1;
        check("mid_stall", 32'(stall), 32'd0);
        check("mid_done",  32'(done),  32'd0);
        check("mid_rdata", 32'(rdata), 32'd0);
        check("mid_err",   32'(err),   32'd0);
        repeat (2) @(negedge clk);
        check("mid_done_hold", 32'(done), 32'd0);
        rst = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check("mid_no_done", 32'(done), 32'd0);
        start(1'b0, 16'h0008, 16'h0000);
        finish("rd_after_mid", 1'b1);

        // Randomized requests, some back-to-back, some with idle gaps
        @(negedge clk);
        for (int n = 0; n < 60; n++) begin
            w = 1'($urandom_range(0, 1));
            a = 16'($urandom);
            a[8:1] = 8'($urandom_range(0, 7));
            a[0] = ($urandom_range(0, 5) == 0);
            d = 16'($urandom);
            start(w, a, d);
            if ($urandom_range(0, 1) == 1 && n != 59) begin
                finish("rand", 1'b0);
            end else begin
                finish("rand", 1'b1);
                repeat ($urandom_range(1, 3)) begin
                    @(negedge clk);
                    check("rand_idle_done", 32'(done), 32'd0);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
